// File: rtl/seq_shift_add_multiplier.sv
// seq_shift_add_multiplier: unsigned WIDTH x WIDTH multiplier, one shift-add per clock.
// An operand pair is taken over an in_valid/in_ready handshake. The 2*WIDTH-bit product
// is returned over an out_valid/out_ready handshake exactly WIDTH cycles after accept.
module seq_shift_add_multiplier #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   sum;
    logic             last_step;

    // Conditional add of the multiplicand into the upper half; the carry-out is kept in sum[WIDTH].
    always_comb begin
        sum = {1'b0, acc_hi};
        if (acc_lo[0]) begin
            sum = {1'b0, acc_hi} + {1'b0, mcand};
        end
    end

    assign last_step = (cnt == CW'(WIDTH - 1));

    // Control FSM and datapath registers; in_ready/out_valid are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            mcand     <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand    <= a;
                        acc_hi   <= '0;
                        acc_lo   <= b;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    // Right shift of {sum, acc_lo}; the consumed multiplier bit acc_lo[0] drops out.
                    acc_hi <= sum[WIDTH:1];
                    acc_lo <= {sum[0], acc_lo[WIDTH-1:1]};
                    cnt    <= cnt + CW'(1);
                    if (last_step) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign product = {acc_hi, acc_lo};

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// tb_seq_shift_add_multiplier: directed and seeded-random checks of the shift-add multiplier.
module tb_seq_shift_add_multiplier;

    localparam int unsigned W = 32;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] product;

    int n_checks;
    int n_fail;
    int cyc;

    // Per-operation results filled in by the stimulus tasks.
    int             acc_cyc;
    int             lat;
    bit             timed_out;
    bit             ready_seen;
    logic [2*W-1:0] got;

    seq_shift_add_multiplier #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for in_ready, present one operand pair, return just after the accept edge.
    task automatic start_op(input logic [W-1:0] ain, input logic [W-1:0] bin);
        int guard;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 100) begin
            step();
            guard++;
        end
        in_valid = 1'b1;
        a        = ain;
        b        = bin;
        step();
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    // Count cycles from the accept until out_valid; note any in_ready=1 seen meanwhile.
    task automatic wait_valid();
        lat        = 0;
        timed_out  = 1'b0;
        ready_seen = 1'b0;
        while (out_valid !== 1'b1) begin
            if (in_ready !== 1'b0) ready_seen = 1'b1;
            if (lat >= 64) begin
                timed_out = 1'b1;
                break;
            end
            step();
            lat++;
        end
        if (in_ready !== 1'b0) ready_seen = 1'b1;
        got = product;
    endtask

    // Complete the output handshake with a one-cycle out_ready pulse.
    task automatic release_op();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        n_checks++;
        if (product !== 64'h0) begin n_fail++; $display("FAIL reset_product got=%h exp=0", product); end
    endtask

    task automatic test_basic();
        start_op(32'd3, 32'd5);
        wait_valid();
        n_checks++;
        if (timed_out || lat != 32) begin n_fail++; $display("FAIL basic_latency got=%0d exp=32", lat); end
        n_checks++;
        if (got !== 64'd15) begin n_fail++; $display("FAIL basic_product got=%0d exp=15", got); end
        n_checks++;
        if (ready_seen) begin n_fail++; $display("FAIL basic_in_ready_busy got=1 exp=0"); end
        release_op();
    endtask

    task automatic test_carry();
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_valid();
        n_checks++;
        if (timed_out || got !== 64'hFFFF_FFFE_0000_0001) begin
            n_fail++; $display("FAIL carry_ones got=%h exp=fffffffe00000001", got);
        end
        release_op();
        start_op(32'h8000_0000, 32'd2);
        wait_valid();
        n_checks++;
        if (timed_out || got !== 64'h0000_0001_0000_0000) begin
            n_fail++; $display("FAIL carry_msb got=%h exp=0000000100000000", got);
        end
        release_op();
    endtask

    task automatic test_backpressure();
        bit bad_prod;
        bit bad_valid;
        bit bad_ready;
        bad_prod  = 1'b0;
        bad_valid = 1'b0;
        bad_ready = 1'b0;
        start_op(32'h1234, 32'h5678);
        wait_valid();
        n_checks++;
        if (timed_out || got !== 64'h0626_0060) begin n_fail++; $display("FAIL bp_product got=%h exp=06260060", got); end
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            a        = 32'hA5A5_0000 + 32'(i);
            b        = 32'h0000_5A5A + 32'(i);
            step();
            if (product !== 64'h0626_0060) bad_prod = 1'b1;
            if (out_valid !== 1'b1) bad_valid = 1'b1;
            if (in_ready !== 1'b0) bad_ready = 1'b1;
        end
        in_valid = 1'b0;
        n_checks++;
        if (bad_prod) begin n_fail++; $display("FAIL bp_product_hold got=changed exp=06260060"); end
        n_checks++;
        if (bad_valid) begin n_fail++; $display("FAIL bp_out_valid_hold got=dropped exp=1"); end
        n_checks++;
        if (bad_ready) begin n_fail++; $display("FAIL bp_in_ready_hold got=1 exp=0"); end
        release_op();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_release got=%0b/%0b exp=0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        seen = 1'b0;
        start_op(32'h100, 32'h100);
        for (int i = 0; i < 10; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_flags got=%0b/%0b exp=1/0", in_ready, out_valid);
        end
        for (int i = 0; i < 40; i++) begin
            step();
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin n_fail++; $display("FAIL mid_reset_no_output got=1 exp=0"); end
        start_op(32'd7, 32'd9);
        wait_valid();
        n_checks++;
        if (timed_out || got !== 64'd63) begin n_fail++; $display("FAIL mid_reset_next got=%0d exp=63", got); end
        release_op();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0]   va [3];
        logic [W-1:0]   vb [3];
        logic [2*W-1:0] ve [3];
        int             prev_acc;
        va[0] = 32'h0;    vb[0] = 32'h1234;  ve[0] = 64'h0;
        va[1] = 32'h1234; vb[1] = 32'h0;     ve[1] = 64'h0;
        va[2] = 32'hFFFF; vb[2] = 32'h10001; ve[2] = 64'hFFFF_FFFF;
        prev_acc = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start_op(va[i], vb[i]);
            if (i > 0) begin
                n_checks++;
                if (acc_cyc - prev_acc != 34) begin
                    n_fail++; $display("FAIL b2b_spacing_%0d got=%0d exp=34", i, acc_cyc - prev_acc);
                end
            end
            prev_acc = acc_cyc;
            wait_valid();
            n_checks++;
            if (timed_out || lat != 32 || got !== ve[i]) begin
                n_fail++; $display("FAIL b2b_result_%0d got=%h lat=%0d exp=%h lat=32", i, got, lat, ve[i]);
            end
        end
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        integer         seed;
        logic [W-1:0]   ra;
        logic [W-1:0]   rb;
        logic [2*W-1:0] exp_p;
        seed = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            ra    = $random(seed);
            rb    = $random(seed);
            exp_p = {32'h0, ra} * {32'h0, rb};
            start_op(ra, rb);
            wait_valid();
            n_checks++;
            if (timed_out || got !== exp_p) begin
                n_fail++;
                $display("FAIL random_%0d a=%0d b=%0d got=%0d exp=%0d", i, ra, rb, got, exp_p);
            end
        end
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        cyc       = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        test_reset();
        test_basic();
        test_carry();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
